// File: rtl/noc_router_pkg.sv
// rtl/noc_router_pkg.sv - shared types and port indices for the 5-port NoC router
//
// Purpose: allocator state encoding and router port index constants.
// Ports:   none (package).

package noc_router_pkg;

  typedef enum logic {
    ALLOC_IDLE,
    ALLOC_LOCKED
  } alloc_state_t;

  localparam int LOCAL = 0;
  localparam int NORTH = 1;
  localparam int SOUTH = 2;
  localparam int EAST  = 3;
  localparam int WEST  = 4;

endpackage

// File: rtl/rr_priority_select.sv
// rtl/rr_priority_select.sv - combinational cyclic first-one search from a rotating pointer
//
// Purpose: pick the first set bit of i_eligible at or after i_rr_ptr, wrapping at NUM_INPUTS.
// Ports:
//   i_eligible  in  NUM_INPUTS  candidate inputs
//   i_rr_ptr    in  SEL_WIDTH   search start index, always < NUM_INPUTS
//   o_onehot    out NUM_INPUTS  one-hot winner, zero when nothing is eligible
//   o_idx       out SEL_WIDTH   winner index, zero when nothing is eligible
//   o_any       out 1           at least one input is eligible

module rr_priority_select #(
  parameter int NUM_INPUTS = 5,
  parameter int SEL_WIDTH  = $clog2(NUM_INPUTS)
) (
  input  logic [NUM_INPUTS-1:0] i_eligible,
  input  logic [SEL_WIDTH-1:0]  i_rr_ptr,
  output logic [NUM_INPUTS-1:0] o_onehot,
  output logic [SEL_WIDTH-1:0]  o_idx,
  output logic                  o_any
);

  always_comb begin : p_search
    int v_pos;
    v_pos    = 0;
    o_any    = 1'b0;
    o_idx    = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      // i_rr_ptr < NUM_INPUTS, so a single subtraction is enough to wrap
      v_pos = int'(i_rr_ptr) + k;
      if (v_pos >= NUM_INPUTS) begin
        v_pos = v_pos - NUM_INPUTS;
      end
      if (!o_any && i_eligible[v_pos]) begin
        o_any = 1'b1;
        o_idx = SEL_WIDTH'(v_pos);
      end
    end
    o_onehot = o_any ? (NUM_INPUTS'(1) << o_idx) : '0;
  end

endmodule

// File: rtl/noc_output_port_allocator.sv
// rtl/noc_output_port_allocator.sv - per-output wormhole allocator with downstream credit tracking
//
// Purpose: grants one input per cycle to this output, holding the output for the owning input from
//          head to tail flit, and never sends without a downstream credit.
// Ports:
//   clk_noc       in  1             NoC clock
//   rst_noc_sync  in  1             synchronous active-high reset
//   req           in  NUM_INPUTS    input i has a flit for this output
//   req_is_tail   in  NUM_INPUTS    that flit is a tail (single-flit packet = head and tail)
//   turn_disable  in  NUM_INPUTS    static forbidden turns
//   credit_in     in  1             downstream freed one slot
//   grant         out NUM_INPUTS    one-hot or zero, combinational
//   send_out      out 1             a flit leaves this cycle
//   out_sel       out SEL_WIDTH     crossbar select, valid with send_out
//   locked        out 1             output held by an unfinished packet
//   credits       out CREDIT_WIDTH  current credit count
//   credit_err    out 1             sticky credit overflow flag

module noc_output_port_allocator
  import noc_router_pkg::*;
#(
  parameter int NUM_INPUTS        = 5,
  parameter int FLIT_BUFFER_DEPTH = 8,
  parameter int CREDIT_WIDTH      = $clog2(FLIT_BUFFER_DEPTH + 1),
  parameter int SEL_WIDTH         = $clog2(NUM_INPUTS)
) (
  input  logic                    clk_noc,
  input  logic                    rst_noc_sync,
  input  logic [NUM_INPUTS-1:0]   req,
  input  logic [NUM_INPUTS-1:0]   req_is_tail,
  input  logic [NUM_INPUTS-1:0]   turn_disable,
  input  logic                    credit_in,
  output logic [NUM_INPUTS-1:0]   grant,
  output logic                    send_out,
  output logic [SEL_WIDTH-1:0]    out_sel,
  output logic                    locked,
  output logic [CREDIT_WIDTH-1:0] credits,
  output logic                    credit_err
);

  localparam logic [CREDIT_WIDTH-1:0] MAX_CREDITS = CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);

  alloc_state_t            r_state;
  logic [SEL_WIDTH-1:0]    r_owner;
  logic [SEL_WIDTH-1:0]    r_rr_ptr;
  logic [CREDIT_WIDTH-1:0] r_credits;
  logic                    r_credit_err;

  logic [NUM_INPUTS-1:0]   w_eligible;
  logic [NUM_INPUTS-1:0]   w_win_onehot;
  logic [SEL_WIDTH-1:0]    w_win_idx;
  logic                    w_win_any;
  logic                    w_can_send;
  logic [NUM_INPUTS-1:0]   w_grant;
  logic [SEL_WIDTH-1:0]    w_sel;
  logic                    w_send;
  logic                    w_tail_sent;

  function automatic logic [SEL_WIDTH-1:0] next_idx(input logic [SEL_WIDTH-1:0] idx);
    return (int'(idx) == NUM_INPUTS - 1) ? '0 : idx + SEL_WIDTH'(1);
  endfunction

  assign w_eligible = req & ~turn_disable;
  assign w_can_send = (r_credits != '0);

  rr_priority_select #(
    .NUM_INPUTS (NUM_INPUTS),
    .SEL_WIDTH  (SEL_WIDTH)
  ) u_rr_select (
    .i_eligible (w_eligible),
    .i_rr_ptr   (r_rr_ptr),
    .o_onehot   (w_win_onehot),
    .o_idx      (w_win_idx),
    .o_any      (w_win_any)
  );

  // Grant is combinational so a flit can leave in the same cycle its request appears.
  // While locked, only the owner is considered and its turn_disable bit is not consulted.
  always_comb begin
    w_grant = '0;
    w_sel   = '0;
    case (r_state)
      ALLOC_IDLE: begin
        w_sel = w_win_idx;
        if (w_win_any && w_can_send) begin
          w_grant = w_win_onehot;
        end
      end
      ALLOC_LOCKED: begin
        w_sel = r_owner;
        if (req[r_owner] && w_can_send) begin
          w_grant[r_owner] = 1'b1;
        end
      end
      default: begin
        w_grant = '0;
        w_sel   = '0;
      end
    endcase
  end

  assign w_send      = |w_grant;
  assign w_tail_sent = |(w_grant & req_is_tail);

  always_ff @(posedge clk_noc) begin
    if (rst_noc_sync) begin
      r_state      <= ALLOC_IDLE;
      r_owner      <= '0;
      r_rr_ptr     <= '0;
      r_credits    <= MAX_CREDITS;
      r_credit_err <= 1'b0;
    end else begin
      if (w_send) begin
        case (r_state)
          ALLOC_IDLE: begin
            if (w_tail_sent) begin
              r_rr_ptr <= next_idx(w_sel);
            end else begin
              r_state <= ALLOC_LOCKED;
              r_owner <= w_sel;
            end
          end
          ALLOC_LOCKED: begin
            if (w_tail_sent) begin
              r_state  <= ALLOC_IDLE;
              r_rr_ptr <= next_idx(r_owner);
            end
          end
          default: r_state <= ALLOC_IDLE;
        endcase
      end

      // A send and a returned credit in the same cycle cancel out.
      case ({w_send, credit_in})
        2'b10: r_credits <= r_credits - CREDIT_WIDTH'(1);
        2'b01: begin
          if (r_credits == MAX_CREDITS) begin
            r_credit_err <= 1'b1;
          end else begin
            r_credits <= r_credits + CREDIT_WIDTH'(1);
          end
        end
        default: r_credits <= r_credits;
      endcase
    end
  end

  assign grant      = w_grant;
  assign send_out   = w_send;
  assign out_sel    = w_sel;
  assign locked     = (r_state == ALLOC_LOCKED);
  assign credits    = r_credits;
  assign credit_err = r_credit_err;

endmodule

// File: tb/tb_noc_output_port_allocator.sv
// tb/tb_noc_output_port_allocator.sv - scoreboard bench for the output port allocator

module tb_noc_output_port_allocator;

  logic       clk_noc = 1'b0;
  logic       rst_noc_sync = 1'b1;
  logic [4:0] req = '0;
  logic [4:0] req_is_tail = '0;
  logic [4:0] turn_disable = '0;
  logic       credit_in = 1'b0;
  logic [4:0] grant;
  logic       send_out;
  logic [2:0] out_sel;
  logic       locked;
  logic [3:0] credits;
  logic       credit_err;

  noc_output_port_allocator dut (
    .clk_noc      (clk_noc),
    .rst_noc_sync (rst_noc_sync),
    .req          (req),
    .req_is_tail  (req_is_tail),
    .turn_disable (turn_disable),
    .credit_in    (credit_in),
    .grant        (grant),
    .send_out     (send_out),
    .out_sel      (out_sel),
    .locked       (locked),
    .credits      (credits),
    .credit_err   (credit_err)
  );

  always #5 clk_noc = ~clk_noc;

  typedef struct {
    string      name;
    logic [4:0] grant;
    logic       locked;
    logic [3:0] credits;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic cmp(input string name, input string field, input int act, input int expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s.%s: got %0d expected %0d", name, field, act, expv);
    end
  endtask

  function automatic int onehot_idx(input logic [4:0] v);
    for (int i = 0; i < 5; i++) begin
      if (v[i]) return i;
    end
    return 0;
  endfunction

  // Monitor: every cycle with a pending expectation, compare all outputs.
  always @(negedge clk_noc) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      cmp(e.name, "grant", int'(grant), int'(e.grant));
      cmp(e.name, "send_out", int'(send_out), int'(|e.grant));
      if (|e.grant) cmp(e.name, "out_sel", int'(out_sel), onehot_idx(e.grant));
      cmp(e.name, "locked", int'(locked), int'(e.locked));
      cmp(e.name, "credits", int'(credits), int'(e.credits));
      cmp(e.name, "credit_err", int'(credit_err), int'(e.err));
    end
  end

  task automatic step(input string name, input logic rst, input logic [4:0] r, input logic [4:0] t,
                      input logic [4:0] td, input logic ci, input logic [4:0] eg,
                      input logic el, input logic [3:0] ec, input logic ee);
    exp_t e;
    @(posedge clk_noc);
    #1;
    rst_noc_sync = rst;
    req          = r;
    req_is_tail  = t;
    turn_disable = td;
    credit_in    = ci;
    e.name = name; e.grant = eg; e.locked = el; e.credits = ec; e.err = ee;
    exp_q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk_noc);

    //            name        rst  req       tail      td        cin  grant     lk cred ee
    step("reset",     0, 5'b00000, 5'b00000, 5'b00000, 0, 5'b00000, 0, 8, 0);
    // single flit on input 2 -> rr_ptr=3; then input 3 -> rr_ptr=4
    step("single2",   0, 5'b00100, 5'b00100, 5'b00000, 0, 5'b00100, 0, 8, 0);
    step("single3",   0, 5'b01000, 5'b01000, 5'b00000, 0, 5'b01000, 0, 7, 0);
    // 3-flit packet on input 1 while input 3 waits; search from 4 finds 1 first
    step("pkt1_head", 0, 5'b01010, 5'b01000, 5'b00000, 0, 5'b00010, 0, 6, 0);
    step("pkt1_body", 0, 5'b01010, 5'b01000, 5'b00000, 0, 5'b00010, 1, 5, 0);
    step("pkt1_tail", 0, 5'b01010, 5'b01010, 5'b00000, 0, 5'b00010, 1, 4, 0);
    step("after1_3",  0, 5'b01000, 5'b01000, 5'b00000, 0, 5'b01000, 0, 3, 0);
    // head on input 0 (rr_ptr=4 -> wraps to 0), then reset mid-packet
    step("pkt0_head", 0, 5'b00001, 5'b00000, 5'b00000, 0, 5'b00001, 0, 2, 0);
    step("rst_mid",   1, 5'b00001, 5'b00000, 5'b00000, 0, 5'b00001, 1, 1, 0);
    step("post_rst",  0, 5'b00000, 5'b00000, 5'b00000, 0, 5'b00000, 0, 8, 0);

    // all inputs single flits with a credit back each cycle: 0,1,2,3,4,0 back to back
    for (int k = 0; k < 6; k++) begin
      logic [4:0] g;
      g = 5'b00001 << (k % 5);
      step("rr_all", 0, 5'b11111, 5'b11111, 5'b00000, 1, g, 0, 8, 0);
    end

    // rr_ptr=1; drain all 8 credits with single flits on input 1
    for (int k = 0; k < 8; k++) begin
      step("drain", 0, 5'b00010, 5'b00010, 5'b00000, 0, 5'b00010, 0, 4'(8 - k), 0);
    end
    step("no_credit",  0, 5'b00010, 5'b00010, 5'b00000, 0, 5'b00000, 0, 0, 0);
    step("credit_in0", 0, 5'b00010, 5'b00010, 5'b00000, 1, 5'b00000, 0, 0, 0);
    step("one_more",   0, 5'b00010, 5'b00010, 5'b00000, 0, 5'b00010, 0, 1, 0);
    step("blocked",    0, 5'b00010, 5'b00010, 5'b00000, 0, 5'b00000, 0, 0, 0);
    step("credit_in1", 0, 5'b00010, 5'b00010, 5'b00000, 1, 5'b00000, 0, 0, 0);
    step("send_and_ci",0, 5'b00010, 5'b00010, 5'b00000, 1, 5'b00010, 0, 1, 0);
    step("send_last",  0, 5'b00010, 5'b00010, 5'b00000, 0, 5'b00010, 0, 1, 0);
    for (int k = 0; k < 8; k++) begin
      step("refill", 0, 5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 0, 4'(k), 0);
    end

    // forbidden turn from input 4: never granted
    for (int k = 0; k < 3; k++) begin
      step("turn_dis", 0, 5'b10000, 5'b10000, 5'b10000, 0, 5'b00000, 0, 8, 0);
    end

    // rr_ptr=2: packet on input 2, owner bubbles for 2 cycles while others request
    step("bub_head",   0, 5'b00100, 5'b00000, 5'b00000, 0, 5'b00100, 0, 8, 0);
    step("bubble_a",   0, 5'b11001, 5'b11001, 5'b00000, 0, 5'b00000, 1, 7, 0);
    step("bubble_b",   0, 5'b11001, 5'b11001, 5'b00000, 0, 5'b00000, 1, 7, 0);
    step("bub_tail",   0, 5'b11101, 5'b11101, 5'b00000, 0, 5'b00100, 1, 7, 0);
    step("bub_next",   0, 5'b11001, 5'b11001, 5'b00000, 0, 5'b01000, 0, 6, 0);

    // refill to 8, then overflow credit sets the sticky error
    step("refill2",    0, 5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 0, 5, 0);
    step("refill2",    0, 5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 0, 6, 0);
    step("refill2",    0, 5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 0, 7, 0);
    step("overflow",   0, 5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 0, 8, 0);
    step("err_sticky", 0, 5'b00000, 5'b00000, 5'b00000, 0, 5'b00000, 0, 8, 1);
    step("err_sticky2",0, 5'b00001, 5'b00001, 5'b00000, 0, 5'b00001, 0, 8, 1);
    step("err_rst",    1, 5'b00000, 5'b00000, 5'b00000, 0, 5'b00000, 0, 7, 1);
    step("err_clear",  0, 5'b00000, 5'b00000, 5'b00000, 0, 5'b00000, 0, 8, 0);

    @(posedge clk_noc);
    @(negedge clk_noc);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
